// File: rtl/toast_hazard_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use / scoreboard /
// structural / WAW stall generation, a small scoreboard tracking in-flight
// long-latency (MALU) writebacks, control-transfer flush sequencing and a
// saturating stall-cycle counter.
//
// Handshake: an MALU issue is a level request on issue_multi_i; it is
// accepted on the rising edge where issue_multi_i=1, stall_o=0 and
// IF_ID_flush_o=0. The requester must hold the request until that edge.
module toast_hazard_unit #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int FWD_STAGES         = 2,
    parameter int SB_SLOTS           = 4,
    parameter int LAT_WIDTH          = 4,
    parameter int FLUSH_CYCLES       = 2,
    localparam int AW = REGFILE_ADDR_WIDTH,
    localparam int SW = $clog2(FWD_STAGES + 1),
    localparam int CW = $clog2(SB_SLOTS + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [FWD_STAGES*AW-1:0] fwd_rd_addr_i,
    input  logic [FWD_STAGES-1:0]    fwd_rd_wr_en_i,
    input  logic [AW-1:0]            id_rs1_addr_i,
    input  logic [AW-1:0]            id_rs2_addr_i,
    input  logic                     id_use_rs1_i,
    input  logic                     id_use_rs2_i,
    input  logic                     ex_load_i,
    input  logic                     issue_multi_i,
    input  logic [AW-1:0]            issue_rd_i,
    input  logic [LAT_WIDTH-1:0]     issue_lat_i,
    input  logic                     branch_taken_i,
    input  logic                     jump_taken_i,
    output logic [SW-1:0]            forwardA_o,
    output logic [SW-1:0]            forwardB_o,
    output logic                     stall_o,
    output logic                     IF_ID_flush_o,
    output logic                     EX_flush_o,
    output logic [CW-1:0]            sb_count_o,
    output logic                     multi_wb_o,
    output logic [31:0]              stall_cycles_o
);

    localparam int FLW = 3;

    // Scoreboard storage
    logic [SB_SLOTS-1:0]  sb_valid_q;
    logic [AW-1:0]        sb_rd_q  [SB_SLOTS];
    logic [LAT_WIDTH-1:0] sb_cnt_q [SB_SLOTS];

    logic [FLW-1:0]       flush_cnt_q;
    logic [31:0]          stall_cnt_q;

    logic [AW-1:0]        ex_rd;
    logic                 load_use_stall;
    logic                 sb_stall;
    logic                 full_stall;
    logic                 waw_stall;
    logic                 flush_event;
    logic                 issue_accept;
    logic [SB_SLOTS-1:0]  retire_vec;
    logic [SB_SLOTS-1:0]  alloc_oh;
    logic                 alloc_found;

    assign ex_rd       = fwd_rd_addr_i[AW-1:0];
    assign flush_event = branch_taken_i | jump_taken_i;

    // Forwarding select: scan oldest to youngest so the youngest match wins
    always_comb begin
        forwardA_o = '0;
        forwardB_o = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (id_use_rs1_i && fwd_rd_wr_en_i[k] &&
                (fwd_rd_addr_i[k*AW +: AW] != '0) &&
                (fwd_rd_addr_i[k*AW +: AW] == id_rs1_addr_i)) begin
                forwardA_o = SW'(k + 1);
            end
            if (id_use_rs2_i && fwd_rd_wr_en_i[k] &&
                (fwd_rd_addr_i[k*AW +: AW] != '0) &&
                (fwd_rd_addr_i[k*AW +: AW] == id_rs2_addr_i)) begin
                forwardB_o = SW'(k + 1);
            end
        end
    end

    // Occupancy count and per-slot retire detection
    always_comb begin
        sb_count_o = '0;
        retire_vec = '0;
        for (int i = 0; i < SB_SLOTS; i++) begin
            sb_count_o    = sb_count_o + CW'(sb_valid_q[i]);
            retire_vec[i] = sb_valid_q[i] && (sb_cnt_q[i] == LAT_WIDTH'(1));
        end
    end

    // Stall sources; x0 is excluded from every match
    always_comb begin
        load_use_stall = ex_load_i && (ex_rd != '0) &&
                         ((id_use_rs1_i && (id_rs1_addr_i == ex_rd)) ||
                          (id_use_rs2_i && (id_rs2_addr_i == ex_rd)));
        sb_stall   = 1'b0;
        waw_stall  = 1'b0;
        for (int i = 0; i < SB_SLOTS; i++) begin
            if (sb_valid_q[i] && (sb_rd_q[i] != '0)) begin
                if ((id_use_rs1_i && (id_rs1_addr_i == sb_rd_q[i])) ||
                    (id_use_rs2_i && (id_rs2_addr_i == sb_rd_q[i]))) begin
                    sb_stall = 1'b1;
                end
                if (issue_multi_i && (issue_rd_i == sb_rd_q[i])) begin
                    waw_stall = 1'b1;
                end
            end
        end
        full_stall = issue_multi_i && (sb_count_o == CW'(SB_SLOTS));
        stall_o    = load_use_stall | sb_stall | full_stall | waw_stall;
    end

    // Lowest slot that is free in the current state (a slot retiring this
    // edge is still marked valid, so it is only reusable on the next edge)
    always_comb begin
        alloc_oh    = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < SB_SLOTS; i++) begin
            if (!sb_valid_q[i] && !alloc_found) begin
                alloc_oh[i] = 1'b1;
                alloc_found = 1'b1;
            end
        end
    end

    assign IF_ID_flush_o = flush_event | (flush_cnt_q != '0);
    assign EX_flush_o    = branch_taken_i;
    assign issue_accept  = issue_multi_i & ~stall_o & ~IF_ID_flush_o &
                           (issue_rd_i != '0);

    // Scoreboard countdown, retire and allocation; writeback pulse
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sb_valid_q <= '0;
            multi_wb_o <= 1'b0;
            for (int i = 0; i < SB_SLOTS; i++) begin
                sb_rd_q[i]  <= '0;
                sb_cnt_q[i] <= '0;
            end
        end else begin
            multi_wb_o <= |retire_vec;
            for (int i = 0; i < SB_SLOTS; i++) begin
                if (sb_valid_q[i]) begin
                    if (retire_vec[i]) begin
                        sb_valid_q[i] <= 1'b0;
                    end else begin
                        sb_cnt_q[i] <= sb_cnt_q[i] - LAT_WIDTH'(1);
                    end
                end else if (issue_accept && alloc_oh[i]) begin
                    sb_valid_q[i] <= 1'b1;
                    sb_rd_q[i]    <= issue_rd_i;
                    sb_cnt_q[i]   <= issue_lat_i;
                end
            end
        end
    end

    // Flush countdown; any new control-transfer event reloads it
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flush_cnt_q <= '0;
        end else if (flush_event) begin
            flush_cnt_q <= FLW'(FLUSH_CYCLES - 1);
        end else if (flush_cnt_q != '0) begin
            flush_cnt_q <= flush_cnt_q - FLW'(1);
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;

endmodule
